// File: rtl/seq_div8.sv
// seq_div8 -- sequential signed restoring divider, one quotient bit per clock.
//
// Divides two signed WIDTH-bit operands. Magnitudes are divided unsigned
// (restoring, MSB first) and the signs are reapplied in a final FIX cycle.
// Division truncates toward zero. The remainder takes the dividend's sign.
//
// Ports
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        request, sampled only while idle
//   dividend     signed dividend, captured on the accepting edge
//   divisor      signed divisor, captured on the accepting edge
//   quotient     signed quotient, registered, held until next result
//   remainder    signed remainder, registered, held until next result
//   busy         high while an operation is in flight
//   done         one-cycle pulse when a new result is presented
//   div_by_zero  divisor was 0 (quotient = -1, remainder = dividend)
//   overflow     most-negative / -1 (quotient wraps to most-negative)
//
// Timing (WIDTH=8): start accepted at edge E, CALC at E+1..E+8, FIX at E+9,
// done high in the cycle after E+9. Divide-by-zero skips CALC (FIX at E+1).

module seq_div8 #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t           state_q, state_d;

  // mag_q holds |dividend| on entry. Each CALC step shifts its MSB out into
  // the partial remainder and shifts the new quotient bit in at the LSB.
  // After WIDTH steps it therefore holds Qmag.
  logic [WIDTH-1:0] mag_q,   mag_d;
  logic [WIDTH-1:0] dsr_q,   dsr_d;     // |divisor|
  logic [WIDTH:0]   prem_q,  prem_d;    // partial remainder
  logic [CW-1:0]    cnt_q,   cnt_d;
  logic             sgnq_q,  sgnq_d;    // quotient negative
  logic             sgnr_q,  sgnr_d;    // remainder negative (dividend sign)
  logic             dbz_q,   dbz_d;     // pending divide-by-zero

  logic [WIDTH-1:0] quo_q,   quo_d;
  logic [WIDTH-1:0] rem_q,   rem_d;
  logic             done_q,  done_d;
  logic             dbzo_q,  dbzo_d;
  logic             ovf_q,   ovf_d;

  // Datapath helpers
  logic [WIDTH-1:0] dvd_abs, dsr_abs;
  logic [WIDTH+1:0] shifted;            // {prem, next dividend bit}
  logic [WIDTH:0]   trial;
  logic             fits;
  logic [WIDTH-1:0] rmag, rsrc;

  // |-2^(W-1)| wraps to 2^(W-1). That is still correct as an unsigned magnitude.
  assign dvd_abs = dividend[WIDTH-1] ? -dividend : dividend;
  assign dsr_abs = divisor[WIDTH-1]  ? -divisor  : divisor;

  // The partial remainder is always below the divisor magnitude.
  // Its top bit is therefore zero, and the shifted value cannot lose bits.
  assign shifted = {prem_q, mag_q[WIDTH-1]};
  assign fits    = (shifted >= {2'b00, dsr_q});
  assign trial   = shifted[WIDTH:0] - {1'b0, dsr_q};
  assign rmag    = prem_q[WIDTH-1:0];

  // On divide-by-zero the untouched dividend magnitude is re-signed.
  // This hands the original dividend back as the remainder.
  assign rsrc    = dbz_q ? mag_q : rmag;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    dsr_d   = dsr_q;
    prem_d  = prem_q;
    cnt_d   = cnt_q;
    sgnq_d  = sgnq_q;
    sgnr_d  = sgnr_q;
    dbz_d   = dbz_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = 1'b0;
    dbzo_d  = dbzo_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          mag_d   = dvd_abs;
          dsr_d   = dsr_abs;
          sgnq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          sgnr_d  = dividend[WIDTH-1];
          prem_d  = '0;
          cnt_d   = '0;
          dbz_d   = (divisor == '0);
          state_d = (divisor == '0) ? S_FIX : S_CALC;
        end
      end

      S_CALC: begin
        prem_d = fits ? trial : shifted[WIDTH:0];
        mag_d  = {mag_q[WIDTH-2:0], fits};
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
      end

      S_FIX: begin
        state_d = S_IDLE;
        done_d  = 1'b1;
        rem_d   = sgnr_q ? -rsrc : rsrc;
        if (dbz_q) begin
          quo_d  = '1;
          dbzo_d = 1'b1;
          ovf_d  = 1'b0;
        end else begin
          quo_d  = sgnq_q ? -mag_q : mag_q;
          dbzo_d = 1'b0;
          // Qmag reaches 2^(W-1) only for most-negative / +-1.
          // It is representable only when the result is negative.
          ovf_d  = ~sgnq_q & mag_q[WIDTH-1];
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      mag_q   <= '0;
      dsr_q   <= '0;
      prem_q  <= '0;
      cnt_q   <= '0;
      sgnq_q  <= 1'b0;
      sgnr_q  <= 1'b0;
      dbz_q   <= 1'b0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      dbzo_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mag_q   <= mag_d;
      dsr_q   <= dsr_d;
      prem_q  <= prem_d;
      cnt_q   <= cnt_d;
      sgnq_q  <= sgnq_d;
      sgnr_q  <= sgnr_d;
      dbz_q   <= dbz_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      dbzo_q  <= dbzo_d;
      ovf_q   <= ovf_d;
    end
  end

  assign busy        = (state_q != S_IDLE);
  assign done        = done_q;
  assign quotient    = quo_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbzo_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_div8.sv
// tb_seq_div8 -- directed self-checking bench for seq_div8.
// Outputs are sampled on the falling edge.
// Inputs change on the falling edge, so they are stable at every rising edge.
module tb_seq_div8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [7:0] dividend = '0;
  logic [7:0] divisor = '0;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero, overflow;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  seq_div8 #(.WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .dividend(dividend), .divisor(divisor),
    .quotient(quotient), .remainder(remainder),
    .busy(busy), .done(done),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  // Issues one operation and then scrambles the operand inputs to zero.
  // lat counts falling edges after the accepting edge until done is seen.
  // A value of 10 means done falls in the cycle after E+9; 0 means done timed out.
  // busy_bad counts cycles where busy was low before done, or high with done.
  task automatic run_op(input int a, input int b,
                        output logic [7:0] q, output logic [7:0] r,
                        output logic dz, output logic ov,
                        output int lat, output int busy_bad);
    lat = 0; busy_bad = 0; q = '0; r = '0; dz = 1'b0; ov = 1'b0;
    @(negedge clk);
    dividend = 8'(a); divisor = 8'(b); start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0; dividend = 8'h00; divisor = 8'h00;
    for (int k = 1; k <= 20; k++) begin
      if (k > 1) @(negedge clk);
      if (done) begin
        lat = k;
        if (busy) busy_bad++;
        q = quotient; r = remainder; dz = div_by_zero; ov = overflow;
        break;
      end
      if (!busy) busy_bad++;
    end
  endtask

  task automatic test_reset();
    logic [7:0] q, r; logic dz, ov; int lat, bb, seen; logic was_busy;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({quotient, remainder, busy, done, div_by_zero, overflow} !== 20'h0)
      $display("FAIL reset_state got=%h exp=0", {quotient, remainder, busy, done, div_by_zero, overflow});
    else n_pass++;
    rst_n = 1'b1;
    // Abort 100/7 at E+4
    @(negedge clk);
    dividend = 8'd100; divisor = 8'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(negedge clk);
    was_busy = busy;
    rst_n = 1'b0;
    #1;
    n_checks++;
    if ({was_busy, quotient, remainder, busy, done, div_by_zero, overflow} !== {1'b1, 20'h0})
      $display("FAIL reset_abort busy_before=%b outs=%h exp busy_before=1 outs=0",
               was_busy, {quotient, remainder, busy, done, div_by_zero, overflow});
    else n_pass++;
    @(negedge clk); rst_n = 1'b1;
    seen = 0;
    repeat (15) begin
      @(negedge clk);
      if (done) seen++;
    end
    n_checks++;
    if (seen != 0) $display("FAIL reset_no_done got=%0d dones exp=0", seen);
    else n_pass++;
    run_op(20, 3, q, r, dz, ov, lat, bb);
    n_checks++;
    if ({q, r, dz, ov} !== {8'd6, 8'd2, 2'b00} || lat != 10)
      $display("FAIL reset_then_20div3 got q=%0d r=%0d dz=%b ov=%b lat=%0d exp q=6 r=2 dz=0 ov=0 lat=10",
               $signed(q), $signed(r), dz, ov, lat);
    else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] q, r; logic dz, ov; int lat, bb;
    run_op(100, 7, q, r, dz, ov, lat, bb);
    n_checks++;
    if (lat != 10) $display("FAIL basic_latency got=%0d exp=10", lat);
    else n_pass++;
    n_checks++;
    if (bb != 0) $display("FAIL basic_busy got=%0d bad cycles exp=0", bb);
    else n_pass++;
    n_checks++;
    if ({q, r, dz, ov} !== {8'd14, 8'd2, 2'b00})
      $display("FAIL basic_100div7 got q=%0d r=%0d dz=%b ov=%b exp q=14 r=2 dz=0 ov=0",
               $signed(q), $signed(r), dz, ov);
    else n_pass++;
  endtask

  task automatic test_signs();
    logic [7:0] q, r; logic dz, ov; int lat, bb;
    int tv [6][4] = '{'{-100, 7, -14, -2}, '{100, -7, -14, 2}, '{-100, -7, 14, -2},
                      '{5, 10, 0, 5}, '{-128, 1, -128, 0}, '{127, -128, 0, 127}};
    for (int i = 0; i < 6; i++) begin
      run_op(tv[i][0], tv[i][1], q, r, dz, ov, lat, bb);
      n_checks++;
      if ({q, r, dz, ov} !== {8'(tv[i][2]), 8'(tv[i][3]), 2'b00} || lat != 10 || bb != 0)
        $display("FAIL signs_%0d/%0d got q=%0d r=%0d dz=%b ov=%b lat=%0d bb=%0d exp q=%0d r=%0d lat=10",
                 tv[i][0], tv[i][1], $signed(q), $signed(r), dz, ov, lat, bb, tv[i][2], tv[i][3]);
      else n_pass++;
    end
  endtask

  task automatic test_flags();
    logic [7:0] q, r; logic dz, ov; int lat, bb;
    run_op(-128, -1, q, r, dz, ov, lat, bb);
    n_checks++;
    if ({q, r, dz, ov} !== {8'h80, 8'h00, 2'b01} || lat != 10)
      $display("FAIL ovf_m128divm1 got q=%h r=%h dz=%b ov=%b lat=%0d exp q=80 r=00 dz=0 ov=1 lat=10",
               q, r, dz, ov, lat);
    else n_pass++;
    run_op(50, 0, q, r, dz, ov, lat, bb);
    n_checks++;
    if ({q, r, dz, ov} !== {8'hFF, 8'd50, 2'b10})
      $display("FAIL dbz_50div0 got q=%h r=%0d dz=%b ov=%b exp q=ff r=50 dz=1 ov=0", q, r, dz, ov);
    else n_pass++;
    n_checks++;
    if (lat != 2 || bb != 0) $display("FAIL dbz_latency got lat=%0d bb=%0d exp lat=2 bb=0", lat, bb);
    else n_pass++;
    run_op(9, 3, q, r, dz, ov, lat, bb);
    n_checks++;
    if ({q, r, dz, ov} !== {8'd3, 8'd0, 2'b00})
      $display("FAIL flags_clear_9div3 got q=%0d r=%0d dz=%b ov=%b exp q=3 r=0 dz=0 ov=0",
               $signed(q), $signed(r), dz, ov);
    else n_pass++;
  endtask

  task automatic test_back_to_back();
    int ndone = 0, bad = 0;
    @(negedge clk);
    dividend = 8'd60; divisor = 8'd8; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 35; k++) begin
      @(negedge clk);
      if (done) begin
        ndone++;
        if ((k % 10) != 0 || quotient !== 8'd7 || remainder !== 8'd4) bad++;
      end
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    n_checks++;
    if (ndone != 3) $display("FAIL b2b_count got=%0d exp=3", ndone);
    else n_pass++;
    n_checks++;
    if (bad != 0) $display("FAIL b2b_results got=%0d bad results exp=0", bad);
    else n_pass++;
  endtask

  task automatic test_ignore_start();
    int lat = 0, extra = 0;
    logic [7:0] q = '0, r = '0;
    @(negedge clk);
    dividend = 8'd60; divisor = 8'd8; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (k == 1) begin dividend = 8'd0; divisor = 8'd0; end
      if (k == 2) begin dividend = 8'd1; divisor = 8'd1; start = 1'b1; end  // sampled at E+3
      if (done) begin lat = k; q = quotient; r = remainder; break; end
    end
    start = 1'b0;
    n_checks++;
    if (lat != 10 || q !== 8'd7 || r !== 8'd4)
      $display("FAIL ignore_start got lat=%0d q=%0d r=%0d exp lat=10 q=7 r=4", lat, $signed(q), $signed(r));
    else n_pass++;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    n_checks++;
    if (extra != 0) $display("FAIL ignore_no_queue got=%0d active cycles exp=0", extra);
    else n_pass++;
  endtask

  task automatic test_sweep();
    logic [7:0] q, r; logic dz, ov; int lat, bb;
    int dl [12] = '{-128, -127, -7, -2, -1, 0, 1, 2, 3, 7, 100, 127};
    int eq, er, elat, prod;
    logic ed, eo;
    for (int a = -128; a <= 127; a += 5) begin
      for (int j = 0; j < 12; j++) begin
        int b = dl[j];
        ed = 1'b0; eo = 1'b0; elat = 10;
        if (b == 0) begin eq = -1; er = a; ed = 1'b1; elat = 2; end
        else if (a == -128 && b == -1) begin eq = -128; er = 0; eo = 1'b1; end
        else begin eq = a / b; er = a % b; end
        run_op(a, b, q, r, dz, ov, lat, bb);
        n_checks++;
        if ({q, r, dz, ov} !== {8'(eq), 8'(er), ed, eo} || lat != elat || bb != 0)
          $display("FAIL sweep_%0d/%0d got q=%0d r=%0d dz=%b ov=%b lat=%0d exp q=%0d r=%0d dz=%b ov=%b lat=%0d",
                   a, b, $signed(q), $signed(r), dz, ov, lat, eq, er, ed, eo, elat);
        else n_pass++;
        if (b != 0 && !(a == -128 && b == -1)) begin
          prod = $signed(q) * b + $signed(r);
          n_checks++;
          if (16'(prod) !== 16'(a))
            $display("FAIL sweep_invariant_%0d/%0d got=%0d exp=%0d", a, b, prod, a);
          else n_pass++;
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_signs();
    test_flags();
    test_back_to_back();
    test_ignore_start();
    test_sweep();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
